// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier, 32x32 signed -> 64-bit.
// One Booth step per clock; a full product takes 32 RUN cycles plus a
// one-cycle DONE strobe, then the unit returns to IDLE.
module booth_mul_seq (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] z_low,
    output logic [31:0] z_high
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;

    // The accumulator and multiplicand carry one guard bit so that
    // subtracting the most negative multiplicand cannot overflow.
    logic [32:0] acc;
    logic [32:0] m_reg;
    logic [31:0] q_reg;
    logic        qm1;
    logic [5:0]  count;

    logic [32:0] sum;
    logic [32:0] acc_shift;
    logic [31:0] q_shift;

    // Booth add/subtract on the {Q[0], Q-1} pair, then the arithmetic shift
    // of {A, Q} one place right with the accumulator sign replicated.
    always_comb begin
        sum = acc;
        case ({q_reg[0], qm1})
            2'b01:   sum = acc + m_reg;
            2'b10:   sum = acc - m_reg;
            default: sum = acc;
        endcase
        acc_shift = {sum[32], sum[32:1]};
        q_shift   = {sum[0], q_reg[31:1]};
    end

    // Control FSM with the datapath registers and registered status outputs.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state  <= IDLE;
            acc    <= '0;
            m_reg  <= '0;
            q_reg  <= '0;
            qm1    <= 1'b0;
            count  <= '0;
            z_low  <= '0;
            z_high <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc   <= '0;
                        q_reg <= multiplier;
                        qm1   <= 1'b0;
                        m_reg <= {multiplicand[31], multiplicand};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_shift;
                    q_reg <= q_shift;
                    qm1   <= q_reg[0];
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        z_high <= acc_shift[31:0];
                        z_low  <= q_shift;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/booth_mul_seq.md
BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 Clock  input  1  rising-edge clock for all state; sole clock.
REQ-002 Clear  input  1  synchronous, active-high reset, sampled on rising edge of Clock.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 multiplicand  input  32  signed operand M (driven from Y register); sampled on the accepting edge only.
REQ-005 multiplier  input  32  signed operand Q (driven from bus); sampled on the accepting edge only.
REQ-006 busy  output  1  high while iterating (state RUN).
REQ-007 done  output  1  one-cycle completion strobe; consumer loads Zhigh/Zlow on it.
REQ-008 z_low  output  32  product bits [31:0], registered.
REQ-009 z_high  output  32  product bits [63:32], registered.

Function
REQ-010 States SHALL be IDLE, RUN, DONE; encoding is free.
REQ-011 IDLE: on an edge with start=1, load A=0 (33 bits), Q=multiplier, Qm1=0, M=multiplicand sign-extended to 33 bits, count=0; go to RUN.
REQ-012 IDLE with start=0: hold all state.
REQ-013 RUN: each edge performs one radix-2 Booth step on the pair {Q[0],Qm1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> no add.
REQ-014 Each step then arithmetic-shifts {A,Q,Qm1} right one bit, with A[32] replicated; count increments.
REQ-015 A and M SHALL be 33 bits wide so that M=0x80000000 never overflows the add/subtract.
REQ-016 On the 32nd RUN edge (count reaching 32): {z_high,z_low} <= {A[31:0],Q} post-shift; state -> DONE.
REQ-017 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-018 Latency: start sampled at edge E0; z outputs valid and done=1 in the cycle after E32; done falls after E33.
REQ-019 busy=1 exactly during RUN (32 cycles); busy=0 in IDLE and DONE.
REQ-020 start in RUN or DONE SHALL be ignored (no queueing); operands changing during RUN have no effect.
REQ-021 Back-to-back: start held high continuously yields one accepted op per 34 cycles (E0, E34, ...).
REQ-022 z_high/z_low SHALL hold their last product until the next completion; not modified in RUN.
REQ-023 Result is the exact signed 64-bit two's-complement product for all 2^64 operand pairs.

Reset
REQ-024 Clear=1 at an edge: state=IDLE, count=0, A=Q=M=Qm1=0, z_low=z_high=0, busy=0, done=0.
REQ-025 Clear has priority over start and over any in-flight RUN/DONE activity; an aborted op produces no done and no result update.
REQ-026 start coincident with Clear is dropped; start is accepted from the first edge with Clear=0.

Verification
REQ-027 M=0x00000022, Q=0x00000024, start pulse -> 32 busy cycles, then done=1 with z_high=0x00000000, z_low=0x000004C8.
REQ-028 M=0xFFFFFFFF, Q=0x00000001 -> z_high=0xFFFFFFFF, z_low=0xFFFFFFFF; M=0x80000000, Q=0x80000000 -> z_high=0x40000000, z_low=0x00000000.
REQ-029 M=0x80000000, Q=0x7FFFFFFF -> z_high=0xC0000000, z_low=0x80000000 (checks 33-bit A).
REQ-030 Start op (0x22 x 0x24), assert Clear for one edge at RUN cycle 10 -> busy=0, z outputs 0, no done; next start completes normally.
REQ-031 Pulse start again at RUN cycle 5 with other operands -> ignored; result equals first operands' product; done exactly once.
REQ-032 Randomized 1000 signed pairs against a 64-bit reference model, with start held high -> done spacing exactly 34 cycles, all products match.
